// File: rtl/time_keeper_if.sv
// ============================================================================
// time_keeper_if : clock-controller <-> time_keeper link.  Rev 1.0
// ============================================================================
`default_nettype none

interface time_keeper_if;
  logic       count_en;
  logic       load_en;
  logic [4:0] hour_load;
  logic [5:0] min_load;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_tick;
  logic       day_wrap;
  logic       chime;

  modport master (
    output count_en, load_en, hour_load, min_load,
    input  hour, min, sec, sec_tick, day_wrap, chime
  );

  modport slave (
    input  count_en, load_en, hour_load, min_load,
    output hour, min, sec, sec_tick, day_wrap, chime
  );
endinterface

`default_nettype wire

// File: rtl/time_keeper.sv
// ============================================================================
// time_keeper : 24-hour hh:mm:ss time base with 1 Hz prescaler.  Rev 1.0
// Optional hourly chime enabled by macro TIMEKEEPER_CHIME_EN.
// ============================================================================
`default_nettype none

module time_keeper #(
  parameter int TICK_DIV = 50_000_000
`ifdef TIMEKEEPER_CHIME_EN
  , parameter int CHIME_SECS = 3
`endif
) (
  input  logic          clk,
  input  logic          rst,
  time_keeper_if.slave  bus
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre;
  logic [4:0]       hour_q;
  logic [5:0]       min_q;
  logic [5:0]       sec_q;
  logic             sec_tick_q;
  logic             day_wrap_q;
  logic             tick;
  logic             sec_end;
  logic             min_end;
  logic             hour_end;

  assign tick     = bus.count_en && (pre == PRE_W'(TICK_DIV - 1));
  assign sec_end  = (sec_q  == 6'd59);
  assign min_end  = (min_q  == 6'd59);
  assign hour_end = (hour_q == 5'd23);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre        <= '0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      // A load overrides any coincident tick and restarts the second.
      if (bus.load_en) begin
        pre    <= '0;
        hour_q <= (bus.hour_load > 5'd23) ? 5'd0 : bus.hour_load;
        min_q  <= (bus.min_load  > 6'd59) ? 6'd0 : bus.min_load;
        sec_q  <= 6'd0;
      end else if (bus.count_en) begin
        if (tick) begin
          pre        <= '0;
          sec_tick_q <= 1'b1;
          sec_q      <= sec_end ? 6'd0 : sec_q + 6'd1;
          if (sec_end) begin
            min_q <= min_end ? 6'd0 : min_q + 6'd1;
            if (min_end) begin
              hour_q     <= hour_end ? 5'd0 : hour_q + 5'd1;
              day_wrap_q <= hour_end;
            end
          end
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

  assign bus.hour     = hour_q;
  assign bus.min      = min_q;
  assign bus.sec      = sec_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_wrap = day_wrap_q;

`ifdef TIMEKEEPER_CHIME_EN
  logic       chime_q;
  logic [5:0] chime_cnt;

  // chime_cnt counts seconds elapsed since the chime rose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chime_q   <= 1'b0;
      chime_cnt <= 6'd0;
    end else if (bus.load_en) begin
      chime_q   <= 1'b0;
      chime_cnt <= 6'd0;
    end else if (tick) begin
      if (sec_end && min_end) begin
        chime_q   <= 1'b1;
        chime_cnt <= 6'd0;
      end else if (chime_q) begin
        if (chime_cnt == 6'(CHIME_SECS - 1)) begin
          chime_q   <= 1'b0;
          chime_cnt <= 6'd0;
        end else begin
          chime_cnt <= chime_cnt + 6'd1;
        end
      end
    end
  end

  assign bus.chime = chime_q;
`else
  assign bus.chime = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
// ============================================================================
// tb_time_keeper : randomized self-checking bench for time_keeper.  Rev 1.0
// Honours TIMEKEEPER_CHIME_EN the same way as the design.
// ============================================================================
`default_nettype none

module tb_time_keeper;

  localparam int TICK_DIV   = 4;
  localparam int CHIME_SECS = 3;
`ifdef TIMEKEEPER_CHIME_EN
  localparam bit CHIME_ON = 1'b1;
`else
  localparam bit CHIME_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  time_keeper_if bus();

  time_keeper #(.TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: seconds-of-day plus enabled-cycle phase within the second.
  int tod;
  int phase;
  int chime_left;
  bit exp_tick;
  bit exp_wrap;

  logic [19:0] got;
  assign got = {bus.hour, bus.min, bus.sec, bus.sec_tick, bus.day_wrap, bus.chime};

  function automatic void model_reset();
    tod = 0; phase = 0; chime_left = 0; exp_tick = 1'b0; exp_wrap = 1'b0;
  endfunction

  function automatic void model_edge(bit en, bit ld, int hl, int ml);
    exp_tick = 1'b0;
    exp_wrap = 1'b0;
    if (ld) begin
      tod        = ((hl > 23) ? 0 : hl) * 3600 + ((ml > 59) ? 0 : ml) * 60;
      phase      = 0;
      chime_left = 0;
    end else if (en) begin
      if (phase == TICK_DIV - 1) begin
        phase    = 0;
        tod      = (tod + 1) % 86400;
        exp_tick = 1'b1;
        exp_wrap = (tod == 0);
        if (chime_left > 0) chime_left--;
        if (CHIME_ON && (tod % 3600 == 0)) chime_left = CHIME_SECS;
      end else begin
        phase++;
      end
    end
  endfunction

  function automatic logic [19:0] exp_vec();
    return {5'(tod / 3600), 6'((tod / 60) % 60), 6'(tod % 60),
            exp_tick, exp_wrap, (chime_left > 0)};
  endfunction

  task automatic step(input bit en, input bit ld, input int hl, input int ml);
    bus.count_en  = en;
    bus.load_en   = ld;
    bus.hour_load = 5'(hl);
    bus.min_load  = 6'(ml);
    @(posedge clk);
    model_edge(en, ld, hl, ml);
    #1;
    bus.load_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.count_en = 1'b0; bus.load_en = 1'b0; bus.hour_load = '0; bus.min_load = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (got !== 20'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", got, 20'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count();
    int ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 0, 0);
      if (bus.sec_tick === 1'b1) ticks++;
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL count_cycle%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    checks++;
    if (ticks != 3 || bus.sec !== 6'd3) begin
      errors++; $display("FAIL count_total ticks=%0d sec=%0d exp ticks=3 sec=3", ticks, bus.sec);
    end
  endtask

  task automatic test_day_wrap();
    int wraps = 0;
    step(1'($urandom_range(1)), 1'b1, 23, 59);
    for (int i = 0; i < 60 * TICK_DIV; i++) begin
      step(1'b1, 1'b0, 0, 0);
      if (bus.day_wrap === 1'b1) wraps++;
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL day_wrap_cycle%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    checks++;
    if (wraps != 1 || {bus.hour, bus.min, bus.sec} !== 17'd0) begin
      errors++; $display("FAIL day_wrap_pulse wraps=%0d time=%h exp wraps=1 time=0", wraps,
                         {bus.hour, bus.min, bus.sec});
    end
    wraps = 0;
    step(1'b1, 1'b1, 0, 0);
    if (bus.day_wrap === 1'b1) wraps++;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 0, 0);
      if (bus.day_wrap === 1'b1) wraps++;
    end
    checks++;
    if (wraps != 0) begin
      errors++; $display("FAIL load_zero_no_wrap wraps=%0d exp=0", wraps);
    end
  endtask

  task automatic test_freeze();
    logic [19:0] snap;
    int waited = 0;
    for (int i = 0; i < 8 && phase != 2; i++) step(1'b1, 1'b0, 0, 0);
    snap = got;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, int'($urandom_range(31)), int'($urandom_range(63)));
      checks++;
      if (got !== snap || got !== exp_vec()) begin
        errors++; $display("FAIL freeze_hold%0d got=%h exp=%h", i, got, snap);
      end
    end
    while (waited < 10) begin
      step(1'b1, 1'b0, 0, 0);
      waited++;
      if (bus.sec_tick === 1'b1) break;
    end
    checks++;
    if (waited != 2 || got !== exp_vec()) begin
      errors++; $display("FAIL freeze_resume cycles=%0d got=%h exp cycles=2 vec=%h", waited, got, exp_vec());
    end
  endtask

  task automatic test_load_tick();
    int waited = 0;
    for (int i = 0; i < 8 && phase != 3; i++) step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 12, 34);
    checks++;
    if (got !== {5'd12, 6'd34, 6'd0, 3'b000} || got !== exp_vec()) begin
      errors++; $display("FAIL load_over_tick got=%h exp=%h", got, {5'd12, 6'd34, 6'd0, 3'b000});
    end
    while (waited < 10) begin
      step(1'b1, 1'b0, 0, 0);
      waited++;
      if (bus.sec_tick === 1'b1) break;
    end
    checks++;
    if (waited != TICK_DIV) begin
      errors++; $display("FAIL load_first_tick cycles=%0d exp=%0d", waited, TICK_DIV);
    end
  endtask

  task automatic test_clamp_rst();
    int waited = 0;
    step(1'($urandom_range(1)), 1'b1, 25, 61);
    checks++;
    if (got !== 20'd0) begin
      errors++; $display("FAIL load_clamp got=%h exp=%h", got, 20'd0);
    end
    step(1'b1, 1'b1, 7, 45);
    for (int i = 0; i < TICK_DIV + 2; i++) step(1'b1, 1'b0, 0, 0);
    checks++;
    if (got !== exp_vec() || bus.sec !== 6'd1) begin
      errors++; $display("FAIL pre_reset got=%h exp=%h", got, exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (got !== 20'd0) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", got, 20'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    while (waited < 10) begin
      step(1'b1, 1'b0, 0, 0);
      waited++;
      if (bus.sec_tick === 1'b1) break;
    end
    checks++;
    if (waited != TICK_DIV || got !== exp_vec()) begin
      errors++; $display("FAIL reset_discards_pre cycles=%0d exp=%0d", waited, TICK_DIV);
    end
  endtask

  task automatic test_chime();
    int chime_cycles = 0;
    step(1'b1, 1'b1, 10, 59);
    for (int i = 0; i < 60 * TICK_DIV + 16; i++) begin
      step(1'b1, 1'b0, 0, 0);
      if (bus.chime === 1'b1) chime_cycles++;
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL chime_cycle%0d got=%h exp=%h", i, got, exp_vec());
      end
      if (i == 60 * TICK_DIV - 1) begin
        checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd11, 6'd0, 6'd0}) begin
          errors++; $display("FAIL chime_time got=%h exp=%h", {bus.hour, bus.min, bus.sec},
                             {5'd11, 6'd0, 6'd0});
        end
      end
    end
    checks++;
    if (chime_cycles != (CHIME_ON ? CHIME_SECS * TICK_DIV : 0)) begin
      errors++; $display("FAIL chime_length got=%0d exp=%0d", chime_cycles,
                         CHIME_ON ? CHIME_SECS * TICK_DIV : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bit en = ($urandom_range(3) != 0);
      bit ld = ($urandom_range(49) == 0);
      int hl = ($urandom_range(1) == 1) ? 23 : int'($urandom_range(31));
      int ml = ($urandom_range(1) == 1) ? 59 : int'($urandom_range(63));
      step(en, ld, hl, ml);
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_day_wrap();
    test_freeze();
    test_load_tick();
    test_clamp_rst();
    test_chime();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
